// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - asynchronous SRAM controller bridging a wide host word onto a narrow SRAM bus
//
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   req_valid/req_ready     host request handshake (ready only in IDLE)
//   req_we, req_addr        request type (1 = write) and host word address
//   req_wdata, req_wstrb    write data and byte strobes
//   rvalid, rdata           one-cycle read completion pulse and held read data
//   bvalid                  one-cycle write completion pulse
//   sram_addr, sram_dq_o    SRAM address and write data
//   sram_dq_oe, sram_dq_i   DQ output enable and SRAM read data
//   sram_ce_n/oe_n/we_n     active-low SRAM strobes
//   sram_be_n               active-low byte enables (bit 0 = LB_N, bit 1 = UB_N)
module sram_ctrl #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int BUS_WIDTH   = 32,
    parameter int RD_WAIT     = 1,
    parameter int WR_WAIT     = 1,
    parameter int TURN_CYCLES = 1
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 req_valid,
    output logic                                                 req_ready,
    input  logic                                                 req_we,
    input  logic [ADDR_WIDTH-$clog2(BUS_WIDTH/DATA_WIDTH)-1:0]   req_addr,
    input  logic [BUS_WIDTH-1:0]                                 req_wdata,
    input  logic [BUS_WIDTH/8-1:0]                               req_wstrb,
    output logic                                                 rvalid,
    output logic [BUS_WIDTH-1:0]                                 rdata,
    output logic                                                 bvalid,
    output logic [ADDR_WIDTH-1:0]                                sram_addr,
    output logic [DATA_WIDTH-1:0]                                sram_dq_o,
    output logic                                                 sram_dq_oe,
    input  logic [DATA_WIDTH-1:0]                                sram_dq_i,
    output logic                                                 sram_ce_n,
    output logic                                                 sram_oe_n,
    output logic                                                 sram_we_n,
    output logic [DATA_WIDTH/8-1:0]                              sram_be_n
);

    localparam int BEATS = BUS_WIDTH / DATA_WIDTH;
    localparam int BL    = DATA_WIDTH / 8;
    localparam int BB    = $clog2(BEATS);
    localparam int HAW   = ADDR_WIDTH - BB;
    localparam int SW    = BUS_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, TURN, RD, WR_SETUP, WR_PULSE, WR_HOLD, RESP} state_t;

    state_t               state, state_d;
    logic                 run;
    logic                 last_read;
    logic                 we_q;
    logic [HAW-1:0]       addr_q;
    logic [BUS_WIDTH-1:0] wdata_q;
    logic [SW-1:0]        wstrb_q;
    logic [2:0]           beat, beat_d;
    logic [3:0]           cnt, cnt_d;
    logic [2:0]           turn_cnt, turn_d;
    logic [BUS_WIDTH-1:0] rbuf, rbuf_next;
    logic [BL-1:0]        be_q;
    logic                 load, rd_cap, accept;
    logic [2:0]           wr_nb, hold_nb;

    // In IDLE the request is being captured this edge, so beat setup reads the live inputs.
    logic                 cur_we;
    logic [HAW-1:0]       cur_addr;
    logic [BUS_WIDTH-1:0] cur_wdata;
    logic [SW-1:0]        cur_wstrb;

    assign accept    = req_valid && req_ready;
    assign cur_we    = (state == IDLE) ? req_we    : we_q;
    assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign cur_wstrb = (state == IDLE) ? req_wstrb : wstrb_q;

    // Lowest beat at or after 'start' with any strobe set; BEATS means none left.
    function automatic logic [2:0] first_beat(input logic [SW-1:0] strb, input logic [2:0] start);
        logic [2:0]    r;
        logic [BL-1:0] s;
        r = 3'(BEATS);
        for (int i = BEATS - 1; i >= 0; i--) begin
            s = BL'(strb >> (i * BL));
            if (3'(i) >= start && s != '0) r = 3'(i);
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        beat_d  = beat;
        cnt_d   = cnt;
        turn_d  = turn_cnt;
        load    = 1'b0;
        rd_cap  = 1'b0;
        wr_nb   = first_beat(cur_wstrb, 3'd0);
        hold_nb = first_beat(wstrb_q, beat + 3'd1);
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_d  = '0;
                    beat_d = '0;
                    if (!req_we) begin
                        state_d = RD;
                        load    = 1'b1;
                    end else if (last_read && TURN_CYCLES > 0) begin
                        state_d = TURN;
                        turn_d  = '0;
                    end else if (wr_nb == 3'(BEATS)) begin
                        state_d = RESP;
                    end else begin
                        state_d = WR_SETUP;
                        beat_d  = wr_nb;
                        load    = 1'b1;
                    end
                end
            end
            TURN: begin
                if (turn_cnt == 3'(TURN_CYCLES - 1)) begin
                    if (wr_nb == 3'(BEATS)) begin
                        state_d = RESP;
                    end else begin
                        state_d = WR_SETUP;
                        beat_d  = wr_nb;
                        load    = 1'b1;
                    end
                end else begin
                    turn_d = turn_cnt + 3'd1;
                end
            end
            RD: begin
                if (cnt == 4'(RD_WAIT)) begin
                    rd_cap = 1'b1;
                    cnt_d  = '0;
                    if (beat == 3'(BEATS - 1)) begin
                        state_d = RESP;
                    end else begin
                        beat_d = beat + 3'd1;
                        load   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = '0;
            end
            WR_PULSE: begin
                if (cnt == 4'(WR_WAIT)) state_d = WR_HOLD;
                else                    cnt_d   = cnt + 4'd1;
            end
            WR_HOLD: begin
                if (hold_nb == 3'(BEATS)) begin
                    state_d = RESP;
                end else begin
                    state_d = WR_SETUP;
                    beat_d  = hold_nb;
                    load    = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rbuf_next = rbuf;
        rbuf_next[int'(beat) * DATA_WIDTH +: DATA_WIDTH] = sram_dq_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run       <= 1'b0;
            last_read <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            beat      <= '0;
            cnt       <= '0;
            turn_cnt  <= '0;
            rbuf      <= '0;
            rdata     <= '0;
            sram_addr <= '0;
            sram_dq_o <= '0;
            be_q      <= '1;
        end else begin
            run      <= 1'b1;
            beat     <= beat_d;
            cnt      <= cnt_d;
            turn_cnt <= turn_d;
            if (accept) begin
                we_q      <= req_we;
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                wstrb_q   <= req_wstrb;
                last_read <= !req_we;
            end
            // Address, data and byte enables are set once per beat so they stay stable around WE_N.
            if (load) begin
                sram_addr <= (ADDR_WIDTH'(cur_addr) << BB) | ADDR_WIDTH'(beat_d);
                if (cur_we) begin
                    sram_dq_o <= DATA_WIDTH'(cur_wdata >> (int'(beat_d) * DATA_WIDTH));
                    be_q      <= ~BL'(cur_wstrb >> (int'(beat_d) * BL));
                end
            end
            if (rd_cap) begin
                rbuf <= rbuf_next;
                if (beat == 3'(BEATS - 1)) rdata <= rbuf_next;
            end
        end
    end

    always_comb begin
        req_ready  = (state == IDLE) && run;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        sram_be_n  = '1;
        rvalid     = 1'b0;
        bvalid     = 1'b0;
        case (state)
            RD: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_be_n = '0;
            end
            WR_SETUP, WR_HOLD: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                sram_be_n  = be_q;
            end
            WR_PULSE: begin
                sram_ce_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_dq_oe = 1'b1;
                sram_be_n  = be_q;
            end
            RESP: begin
                rvalid = !we_q;
                bvalid = we_q;
            end
            default: ;
        endcase
    end

endmodule
